rbm_dot_acc: RTL and testbench
==============================

# rbm_dot_acc

Streaming saturating dot-product accumulator for the RBM datapath. It consumes one (weight, visible-bit) beat per cycle and adds the weight when the visible bit is 1. It closes a vector on `in_last` and presents the signed saturated sum to the downstream activation/sampling stage. Every addition uses the team's symmetric-saturation rule: positive overflow clamps to `+INF`, negative overflow clamps to `-INF`, and `-INF` is the negation of `INF`, not the most-negative code.

## Interface
- `BITLENGTH`, default 12: width of weights, bias and sum (two's complement).
- `N_VIS`, default 16: maximum beats per vector. Must be ≥ 2.
- `INF`, default `2**(BITLENGTH-1)-1` (12'h7FF): saturation magnitude.

Ports (`BW` = `BITLENGTH`):
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `in_weight` input BW: signed weight.
- `in_vis` input 1: visible unit state. A value of 1 adds `in_weight`; 0 adds 0.
- `in_last` input 1: final beat of vector.
- `bias` input BW: signed hidden bias. Present only under `RBM_BIAS_EN`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts when `out_valid && out_ready`.
- `out_sum` output BW: signed saturated dot product.
- `out_sat` output 1: at least one addition in this vector saturated.

## Operation
- Internal state: `acc` (BW), `cnt` (⌈log2 N_VIS⌉+1), `sat_seen`, `first` flag.
- FSM states are `ACC` and `FULL`.
  - `ACC`: the output register is free or draining.
  - `FULL`: `out_valid=1` and the output has not yet been accepted.
- `in_ready = !out_valid || out_ready`. One output register, no skid.
- The term for each accepted beat is `in_vis ? in_weight : 0`.
- Each accepted beat computes `s = sat_add(base, term)`:
  - `base` is `acc`, except on the first beat of a vector.
  - On the first beat, `base` is 0, or `bias` under `RBM_BIAS_EN`.
- Saturation rule, with `r = base + term` wrapped to BW bits:
  - If `base > 0 && term > 0 && r ≤ 0`, the sum is `+INF`.
  - If `base < 0 && term < 0 && r ≥ 0`, the sum is `-INF`.
  - Otherwise the sum is `r`.
- Saturation is applied per addition, not sticky: later terms may move the sum away from the rail.
- Non-last beat: `acc ← s`, `cnt++`, and `sat_seen` is ORed with the overflow detect.
- Last beat: `in_last=1`, or `cnt == N_VIS-1` (forced close).
  - `out_sum ← s` and `out_sat ← sat_seen | detect`.
  - `out_valid ← 1`.
  - `acc`, `cnt`, `sat_seen` and `first` are re-armed for the next vector.
- The forced close at `N_VIS` beats is silent. Beats after that start a new vector.
- `in_last` on the first beat gives a one-beat vector.
- Simultaneous events:
  - Output accept plus last-beat accept in the same cycle: `out_valid` stays 1 with the new data.
  - Output accept alone: `out_valid ← 0`.

## Timing
- Reset values (the cycle after `rst_n` is sampled low): `out_valid=0`, `out_sum=0`, `out_sat=0`, `acc=0`, `cnt=0`, `first=1`, FSM in `ACC`.
- `in_ready` is combinational. Its reset value is 1.
- Reset mid-vector discards the partial sum and any held output.
- Latency: `out_valid` rises on the edge that accepts the last beat, i.e. 1 cycle after that beat is presented.
- Throughput: one beat per cycle. No bubble between vectors when `out_ready=1`.
- `out_sum` and `out_sat` are stable while `out_valid && !out_ready`.

## Configuration
- `RBM_BIAS_EN` defined:
  - The `bias` port exists.
  - `bias` is sampled on the first accepted beat of each vector and seeds the sum through a saturating add.
- `RBM_BIAS_EN` undefined:
  - No `bias` port.
  - The first beat adds to 0.
  - Behaviour is otherwise identical.

## Structure
- Package `rbm_pkg` holds:
  - the `BITLENGTH` default;
  - the `INF` constant;
  - the FSM state typedef (`ACC`, `FULL`);
  - the signed word typedef.
- One sub-module, `rbm_sat_add`: a combinational BW-bit symmetric saturating adder with a `sat` flag output. It is instantiated once for the accumulate path.

## Test plan
- Basic sum: weights 5, −3, 100, 7 with vis 1,1,0,1 and last on beat 4 → `out_sum=9`, `out_sat=0`; `out_valid` is high 1 cycle after beat 4.
- Positive clamp then recover: weights 2000, 100, −500, all vis 1 → `+INF`(2047) after beat 2, final `out_sum=1547`, `out_sat=1`.
- Negative clamp: weights −2000, −2000 → `out_sum=-2047` (not −2048), `out_sat=1`.
- Backpressure: hold `out_ready=0` with a result pending → `in_ready=0` and `out_sum` stable. Raise `out_ready` in the same cycle as the next vector's last beat → back-to-back results, no lost beat.
- Forced close: 16 beats of weight 1, vis 1, no `in_last` → `out_sum=16` after beat 16. Beat 17 starts a new vector.
- `RBM_BIAS_EN`: `bias=-10`, weights 4, 4 → `out_sum=-2`. Reset asserted mid-vector → all outputs 0, and the next vector's sum starts from bias.

Source files
------------

// File: rtl/rbm_pkg.sv
// Shared types and constants for the RBM dot-product datapath.
package rbm_pkg;

   localparam int unsigned DEF_BITLENGTH = 12;
   localparam int          DEF_INF       = int'(2**(DEF_BITLENGTH-1)) - 1;

   // Accumulator control: ACC while the output register is free or draining,
   // FULL while a result is held and not yet accepted.
   typedef enum logic {
      ACC  = 1'b0,
      FULL = 1'b1
   } state_t;

   typedef logic signed [DEF_BITLENGTH-1:0] word_t;

endpackage

// File: rtl/rbm_dot_acc_if.sv
// Beat-input / result-output handshake bundle for rbm_dot_acc.
interface rbm_dot_acc_if import rbm_pkg::*; #(
   parameter int unsigned BW = DEF_BITLENGTH
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic signed [BW-1:0] in_weight;
   logic                 in_vis;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [BW-1:0] out_sum;
   logic                 out_sat;

   // Producer of beats / consumer of results.
   modport master (
      output in_valid, in_weight, in_vis, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_sat
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_weight, in_vis, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_sat
   );

endinterface

// File: rtl/rbm_sat_add.sv
// Combinational BW-bit adder with symmetric saturation to +/-INF.
module rbm_sat_add #(
   parameter int unsigned BW  = 12,
   parameter int          INF = 2047
) (
   input  logic signed [BW-1:0] a,
   input  logic signed [BW-1:0] b,
   output logic signed [BW-1:0] s,
   output logic                 sat
);

   localparam logic signed [BW-1:0] ZERO     = '0;
   localparam logic signed [BW-1:0] POS_RAIL = BW'(INF);
   localparam logic signed [BW-1:0] NEG_RAIL = BW'(-INF);

   logic signed [BW-1:0] r;
   logic                 pos_ovf;
   logic                 neg_ovf;

   // Wrapped sum, overflow detect by operand/result sign, clamp to the rails.
   always_comb begin
      r       = a + b;
      pos_ovf = (a > ZERO) && (b > ZERO) && (r <= ZERO);
      neg_ovf = (a < ZERO) && (b < ZERO) && (r >= ZERO);
      if (pos_ovf) begin
         s = POS_RAIL;
      end else if (neg_ovf) begin
         s = NEG_RAIL;
      end else begin
         s = r;
      end
      sat = pos_ovf | neg_ovf;
   end

endmodule

// File: rtl/rbm_dot_acc.sv
// Streaming saturating dot-product accumulator (weight * visible bit).
// Optional hidden-bias seed on the first beat: define RBM_BIAS_EN.
module rbm_dot_acc import rbm_pkg::*; #(
   parameter int unsigned BITLENGTH = DEF_BITLENGTH,
   parameter int unsigned N_VIS     = 16,
   parameter int          INF       = int'(2**(BITLENGTH-1)) - 1
) (
   input logic          clk,
   input logic          rst_n,
   rbm_dot_acc_if.slave bus
`ifdef RBM_BIAS_EN
   ,
   input logic signed [BITLENGTH-1:0] bias
`endif
);

   localparam int unsigned BW    = BITLENGTH;
   localparam int unsigned CNT_W = $clog2(N_VIS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_VIS - 1);

   state_t               state_q;
   state_t               state_d;
   logic signed [BW-1:0] acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 sat_seen_q;
   logic                 first_q;
   logic signed [BW-1:0] out_sum_q;
   logic                 out_sat_q;

   logic                 beat;
   logic                 close;
   logic signed [BW-1:0] seed;
   logic signed [BW-1:0] base;
   logic signed [BW-1:0] term;
   logic signed [BW-1:0] sum;
   logic                 sum_ovf;

`ifdef RBM_BIAS_EN
   assign seed = bias;
`else
   assign seed = '0;
`endif

   // Handshake: single output register, a new result may land as the old one leaves.
   assign bus.out_valid = (state_q == FULL);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_sat   = out_sat_q;

   // Beat decode: accept, vector close (explicit or forced at N_VIS), addend selection.
   always_comb begin
      beat  = bus.in_valid && bus.in_ready;
      close = bus.in_last || (cnt_q == CNT_LAST);
      term  = bus.in_vis ? bus.in_weight : '0;
      base  = first_q ? seed : acc_q;
   end

   rbm_sat_add #(
      .BW  (BW),
      .INF (INF)
   ) u_add (
      .a   (base),
      .b   (term),
      .s   (sum),
      .sat (sum_ovf)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a closing beat (re)fills the output, an accept alone empties it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC: begin
            if (beat && close) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (beat && close) begin
               state_d = FULL;
            end else if (bus.out_ready) begin
               state_d = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   // Accumulator, beat counter and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         sat_seen_q <= 1'b0;
         first_q    <= 1'b1;
         out_sum_q  <= '0;
         out_sat_q  <= 1'b0;
      end else if (beat) begin
         if (close) begin
            out_sum_q  <= sum;
            out_sat_q  <= sat_seen_q | sum_ovf;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_seen_q <= 1'b0;
            first_q    <= 1'b1;
         end else begin
            acc_q      <= sum;
            cnt_q      <= cnt_q + CNT_W'(1);
            sat_seen_q <= sat_seen_q | sum_ovf;
            first_q    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rbm_dot_acc.sv
// Self-checking bench for rbm_dot_acc: vector table plus hand-written corner sequences,
// results checked against a queue of expected values.
module tb_rbm_dot_acc;
   import rbm_pkg::*;

   localparam int unsigned BW = DEF_BITLENGTH;
   localparam int unsigned NV = 16;

   typedef struct packed {
      word_t sum;
      logic  sat;
   } exp_t;

   typedef struct {
      string name;
      int    n;
      int    w [4];
      bit    v [4];
      int    sum;
      bit    sat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
`ifdef RBM_BIAS_EN
   logic signed [BW-1:0] bias = '0;
`endif

   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_results = 0;
   exp_t exp_q [$];

   rbm_dot_acc_if #(.BW(BW)) bus ();

   rbm_dot_acc #(
      .BITLENGTH (BW),
      .N_VIS     (NV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef RBM_BIAS_EN
      ,
      .bias  (bias)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input int n,
                               input int w0, input int w1, input int w2, input int w3,
                               input bit v0, input bit v1, input bit v2, input bit v3,
                               input int sum, input bit sat);
      vec_t r;
      r.name = name;
      r.n    = n;
      r.w[0] = w0; r.w[1] = w1; r.w[2] = w2; r.w[3] = w3;
      r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
      r.sum  = sum;
      r.sat  = sat;
      return r;
   endfunction

   task automatic expect_result(input int sum, input bit sat);
      exp_t e;
      e.sum = BW'(sum);
      e.sat = sat;
      exp_q.push_back(e);
   endtask

   // Present one beat and hold it until accepted (bounded); returns 1 ns after the edge.
   task automatic send_beat(input int w, input bit v, input bit last);
      int waited = 0;
      bus.in_valid  = 1'b1;
      bus.in_weight = BW'(w);
      bus.in_vis    = v;
      bus.in_last   = last;
      @(negedge clk);
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles, required 1", waited);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_sum"},   int'($signed(bus.out_sum)), 0);
      check({tag, "_out_sat"},   int'(bus.out_sat), 0);
      check({tag, "_in_ready"},  int'(bus.in_ready), 1);
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   // Result monitor: every output transfer is compared with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got sum %0d, expected no result", $signed(bus.out_sum));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("out_sum[%0d]", n_results), int'($signed(bus.out_sum)), int'($signed(e.sum)));
            check($sformatf("out_sat[%0d]", n_results), int'(bus.out_sat), int'(e.sat));
            n_results++;
         end
      end
   end

   initial begin
      vec_t tbl [8];
      int   exp_after_rst;

      tbl[0] = mk("basic",      4,  5,    -3,    100,  7,  1,1,0,1,  9,    1'b0);
      tbl[1] = mk("pos_clamp",  3,  2000, 100,   -500, 0,  1,1,1,0,  1547, 1'b1);
      tbl[2] = mk("neg_clamp",  2,  -2000,-2000, 0,    0,  1,1,0,0,  -2047,1'b1);
      tbl[3] = mk("one_beat",   1,  42,   0,     0,    0,  1,0,0,0,  42,   1'b0);
      tbl[4] = mk("min_code",   2,  -2048,-1,    0,    0,  1,1,0,0,  -2047,1'b1);
      tbl[5] = mk("rail_hold",  3,  2047, 1,     -1,   0,  1,1,1,0,  2046, 1'b1);
      tbl[6] = mk("vis_off",    2,  300,  400,   0,    0,  0,0,0,0,  0,    1'b0);
      tbl[7] = mk("exact_rail", 3,  -1000,-1000, -47,  0,  1,1,1,0,  -2047,1'b0);

      bus.in_valid  = 1'b0;
      bus.in_weight = '0;
      bus.in_vis    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;

      @(posedge clk);
      do_reset("reset");

      // Table vectors, back to back with the output always ready.
      foreach (tbl[k]) begin
         for (int b = 0; b < tbl[k].n; b++) begin
            if (b == tbl[k].n - 1) begin
               expect_result(tbl[k].sum, tbl[k].sat);
               send_beat(tbl[k].w[b], tbl[k].v[b], 1'b1);
               check({tbl[k].name, "_latency"}, int'(bus.out_valid), 1);
            end else begin
               send_beat(tbl[k].w[b], tbl[k].v[b], 1'b0);
               check({tbl[k].name, "_no_early_valid"}, int'(bus.out_valid), 0);
            end
         end
      end
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: held result, stalled last beat, then simultaneous accept.
      bus.out_ready = 1'b0;
      expect_result(10, 1'b0);
      send_beat(10, 1'b1, 1'b1);
      bus.in_valid  = 1'b1;
      bus.in_weight = BW'(77);
      bus.in_vis    = 1'b1;
      bus.in_last   = 1'b1;
      expect_result(77, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready",   int'(bus.in_ready), 0);
         check("bp_hold_valid", int'(bus.out_valid), 1);
         check("bp_hold_sum",   int'($signed(bus.out_sum)), 10);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check("bp_b2b_valid", int'(bus.out_valid), 1);
      check("bp_b2b_sum",   int'($signed(bus.out_sum)), 77);
      @(posedge clk);
      #1;
      check("bp_drained", int'(bus.out_valid), 0);

      // Forced close after N_VIS beats; the next beat opens a new vector.
      for (int b = 0; b < int'(NV); b++) begin
         if (b == int'(NV) - 1) expect_result(16, 1'b0);
         send_beat(1, 1'b1, 1'b0);
      end
      check("fc_valid", int'(bus.out_valid), 1);
      check("fc_sum",   int'($signed(bus.out_sum)), 16);
      expect_result(5, 1'b0);
      send_beat(5, 1'b1, 1'b1);
      @(posedge clk);
      #1;

      // Reset discards a held result.
      bus.out_ready = 1'b0;
      expect_result(9, 1'b0);
      send_beat(9, 1'b1, 1'b1);
      check("held_before_rst", int'(bus.out_valid), 1);
      do_reset("rst_held");
      bus.out_ready = 1'b1;

`ifdef RBM_BIAS_EN
      // Bias seeds the first addition, itself saturating.
      bias = -12'sd10;
      expect_result(-2, 1'b0);
      send_beat(4, 1'b1, 1'b0);
      send_beat(4, 1'b1, 1'b1);
      bias = -12'sd2000;
      expect_result(-2047, 1'b1);
      send_beat(-100, 1'b1, 1'b1);
      bias = -12'sd10;
      exp_after_rst = -3;
`else
      exp_after_rst = 7;
`endif

      // Reset mid-vector discards the partial sum.
      send_beat(500, 1'b1, 1'b0);
      send_beat(500, 1'b1, 1'b0);
      do_reset("rst_mid");
      expect_result(exp_after_rst, 1'b0);
      send_beat(7, 1'b1, 1'b1);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
